// File: rtl/frame_slot_sched.sv
// rtl/frame_slot_sched.sv - frame-slot scheduler between frame buffer writer and reader
//
// Purpose: owns FRAMES_AMOUNT DDR frame slots (FREE/WRITING/READY/READING) and
// hands base addresses to the writer DMA and the read controller. The writer and
// the reader each always own one slot. At most one slot is READY, and it holds the
// newest complete frame. Overflow drops the oldest READY frame. Underrun makes the
// reader repeat its current frame.
//
// Ports:
//   clk_i            single clock
//   rst_n_i          asynchronous active-low reset
//   wr_done_i        writer finished its slot (4-phase level)
//   wr_done_ack_o    ack to writer; wr_base_addr_o valid for the next frame
//   wr_base_addr_o   base address of the writer's slot
//   rd_done_i        reader finished its slot (4-phase level)
//   rd_done_ack_o    ack to reader; rd_base_addr_o valid for the next frame
//   rd_base_addr_o   base address of the reader's slot
//   rd_frame_valid_o reader slot holds a completely written frame
//   rd_new_frame_o   1-cycle pulse when the reader switched to a fresh frame
//   drop_cnt_o       READY frames overwritten before being read (saturating)
//   repeat_cnt_o     rd_done events with no READY slot (saturating)

module frame_slot_sched #(
  parameter longint unsigned START_ADDR    = 0,
  parameter int unsigned     FRAMES_AMOUNT = 3,
  parameter longint unsigned FRAME_SIZE_B  = 4147200,
  parameter int unsigned     ADDR_WIDTH    = 32,
  parameter int unsigned     CNT_WIDTH     = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_done_i,
  output logic                  wr_done_ack_o,
  output logic [ADDR_WIDTH-1:0] wr_base_addr_o,
  input  logic                  rd_done_i,
  output logic                  rd_done_ack_o,
  output logic [ADDR_WIDTH-1:0] rd_base_addr_o,
  output logic                  rd_frame_valid_o,
  output logic                  rd_new_frame_o,
  output logic [CNT_WIDTH-1:0]  drop_cnt_o,
  output logic [CNT_WIDTH-1:0]  repeat_cnt_o
);

  localparam int IW = $clog2(FRAMES_AMOUNT);

  typedef enum logic {ACK_IDLE, ACK_BUSY} ack_state_t;

  if (FRAMES_AMOUNT < 3) begin : g_bad_frames
    $error("frame_slot_sched: FRAMES_AMOUNT must be at least 3");
  end

  // Slot base addresses are elaboration-time constants. They are computed in 64 bits
  // and then truncated to the address width.
  logic [ADDR_WIDTH-1:0] addr_tbl [FRAMES_AMOUNT];

  for (genvar g = 0; g < FRAMES_AMOUNT; g++) begin : g_addr
    localparam longint unsigned SLOT_ADDR = START_ADDR + longint'(g) * FRAME_SIZE_B;
    assign addr_tbl[g] = SLOT_ADDR[ADDR_WIDTH-1:0];
  end

  // Slot ownership is tracked as indices. All slots not named here are FREE.
  logic [IW-1:0] wr_idx, rd_idx, rdy_idx;
  logic          rdy_vld;

  logic          wr_done_d1, rd_done_d1;
  ack_state_t    wr_state, rd_state;

  logic          wr_ev, rd_ev;
  logic [IW-1:0] n_wr_idx, n_rd_idx, n_rdy_idx;
  logic          n_rdy_vld;
  logic          drop_inc, repeat_inc, new_frame;

  // The ack term blocks a done that is held or re-raised during the handshake.
  assign wr_ev = wr_done_i & ~wr_done_d1 & ~wr_done_ack_o;
  assign rd_ev = rd_done_i & ~rd_done_d1 & ~rd_done_ack_o;

  // The write update is applied first. A frame completed in this cycle is
  // therefore already visible to a simultaneous read update.
  always_comb begin
    n_wr_idx   = wr_idx;
    n_rd_idx   = rd_idx;
    n_rdy_idx  = rdy_idx;
    n_rdy_vld  = rdy_vld;
    drop_inc   = 1'b0;
    repeat_inc = 1'b0;
    new_frame  = 1'b0;

    if (wr_ev) begin
      drop_inc  = rdy_vld;
      n_rdy_vld = 1'b1;
      n_rdy_idx = wr_idx;
      // The old READY slot (if any) is freed, so the only occupied slots are
      // the new READY slot (the old wr_idx) and the reader's slot. Scanning
      // downward leaves the lowest free index.
      for (int i = FRAMES_AMOUNT - 1; i >= 0; i--) begin
        if (IW'(i) != wr_idx && IW'(i) != rd_idx) n_wr_idx = IW'(i);
      end
    end

    if (rd_ev) begin
      if (n_rdy_vld) begin
        n_rd_idx  = n_rdy_idx;
        n_rdy_vld = 1'b0;
        new_frame = 1'b1;
      end else begin
        repeat_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_idx           <= IW'(0);
      rd_idx           <= IW'(1);
      rdy_idx          <= IW'(0);
      rdy_vld          <= 1'b0;
      wr_done_d1       <= 1'b0;
      rd_done_d1       <= 1'b0;
      wr_state         <= ACK_IDLE;
      rd_state         <= ACK_IDLE;
      wr_done_ack_o    <= 1'b0;
      rd_done_ack_o    <= 1'b0;
      wr_base_addr_o   <= addr_tbl[0];
      rd_base_addr_o   <= addr_tbl[1];
      rd_frame_valid_o <= 1'b0;
      rd_new_frame_o   <= 1'b0;
      drop_cnt_o       <= '0;
      repeat_cnt_o     <= '0;
    end else begin
      wr_done_d1 <= wr_done_i;
      rd_done_d1 <= rd_done_i;

      case (wr_state)
        ACK_IDLE: if (wr_ev) begin
          wr_state      <= ACK_BUSY;
          wr_done_ack_o <= 1'b1;
        end
        ACK_BUSY: if (!wr_done_i) begin
          wr_state      <= ACK_IDLE;
          wr_done_ack_o <= 1'b0;
        end
        default: begin
          wr_state      <= ACK_IDLE;
          wr_done_ack_o <= 1'b0;
        end
      endcase

      case (rd_state)
        ACK_IDLE: if (rd_ev) begin
          rd_state      <= ACK_BUSY;
          rd_done_ack_o <= 1'b1;
        end
        ACK_BUSY: if (!rd_done_i) begin
          rd_state      <= ACK_IDLE;
          rd_done_ack_o <= 1'b0;
        end
        default: begin
          rd_state      <= ACK_IDLE;
          rd_done_ack_o <= 1'b0;
        end
      endcase

      wr_idx         <= n_wr_idx;
      rd_idx         <= n_rd_idx;
      rdy_idx        <= n_rdy_idx;
      rdy_vld        <= n_rdy_vld;
      wr_base_addr_o <= addr_tbl[n_wr_idx];
      rd_base_addr_o <= addr_tbl[n_rd_idx];
      rd_new_frame_o <= new_frame;
      if (new_frame) rd_frame_valid_o <= 1'b1;

      if (drop_inc && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
      if (repeat_inc && repeat_cnt_o != '1) repeat_cnt_o <= repeat_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_slot_sched.sv
// tb/tb_frame_slot_sched.sv - self-checking bench for frame_slot_sched

module tb_frame_slot_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        wr_done = 1'b0, rd_done = 1'b0;
  logic        wr_ack, rd_ack, rd_valid, rd_new;
  logic [31:0] wr_base, rd_base;
  logic [15:0] drop_cnt, repeat_cnt;

  logic        wr_done4 = 1'b0, rd_done4 = 1'b0;
  logic        wr_ack4, rd_ack4, rd_valid4, rd_new4;
  logic [31:0] wr_base4, rd_base4;
  logic [1:0]  drop_cnt4, repeat_cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  frame_slot_sched #(
    .START_ADDR(0), .FRAMES_AMOUNT(3), .FRAME_SIZE_B(32'h1000),
    .ADDR_WIDTH(32), .CNT_WIDTH(16)
  ) dut3 (
    .clk_i(clk), .rst_n_i(rst_n),
    .wr_done_i(wr_done), .wr_done_ack_o(wr_ack), .wr_base_addr_o(wr_base),
    .rd_done_i(rd_done), .rd_done_ack_o(rd_ack), .rd_base_addr_o(rd_base),
    .rd_frame_valid_o(rd_valid), .rd_new_frame_o(rd_new),
    .drop_cnt_o(drop_cnt), .repeat_cnt_o(repeat_cnt)
  );

  frame_slot_sched #(
    .START_ADDR(0), .FRAMES_AMOUNT(4), .FRAME_SIZE_B(32'h1000),
    .ADDR_WIDTH(32), .CNT_WIDTH(2)
  ) dut4 (
    .clk_i(clk), .rst_n_i(rst_n),
    .wr_done_i(wr_done4), .wr_done_ack_o(wr_ack4), .wr_base_addr_o(wr_base4),
    .rd_done_i(rd_done4), .rd_done_ack_o(rd_ack4), .rd_base_addr_o(rd_base4),
    .rd_frame_valid_o(rd_valid4), .rd_new_frame_o(rd_new4),
    .drop_cnt_o(drop_cnt4), .repeat_cnt_o(repeat_cnt4)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    wr_done = 1'b0; rd_done = 1'b0; wr_done4 = 1'b0; rd_done4 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic handshake(input logic w, input logic r);
    wr_done = w; rd_done = r;
    cyc();
    wr_done = 1'b0; rd_done = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (wr_base !== 32'h0) begin n_fail++; $display("FAIL reset_wr_base got %h exp %h", wr_base, 32'h0); end
    n_checks++; if (rd_base !== 32'h1000) begin n_fail++; $display("FAIL reset_rd_base got %h exp %h", rd_base, 32'h1000); end
    n_checks++; if ({wr_ack, rd_ack, rd_valid, rd_new} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {wr_ack, rd_ack, rd_valid, rd_new}); end
    n_checks++; if ({drop_cnt, repeat_cnt} !== 32'h0) begin n_fail++; $display("FAIL reset_counters got %h exp 0", {drop_cnt, repeat_cnt}); end
  endtask

  task automatic test_write_then_read();
    apply_reset();
    wr_done = 1'b1;
    cyc();
    n_checks++; if (wr_ack !== 1'b1) begin n_fail++; $display("FAIL wr_ack_rise got %b exp 1", wr_ack); end
    n_checks++; if (wr_base !== 32'h2000) begin n_fail++; $display("FAIL wr_base_first got %h exp %h", wr_base, 32'h2000); end
    cyc();
    n_checks++; if (wr_ack !== 1'b1 || wr_base !== 32'h2000) begin n_fail++; $display("FAIL wr_hold got ack %b base %h exp 1 2000", wr_ack, wr_base); end
    wr_done = 1'b0;
    cyc();
    n_checks++; if (wr_ack !== 1'b0) begin n_fail++; $display("FAIL wr_ack_drop got %b exp 0", wr_ack); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL valid_before_read got %b exp 0", rd_valid); end
    rd_done = 1'b1;
    cyc();
    n_checks++; if (rd_base !== 32'h0) begin n_fail++; $display("FAIL rd_base_first got %h exp %h", rd_base, 32'h0); end
    n_checks++; if ({rd_ack, rd_new, rd_valid} !== 3'b111) begin n_fail++; $display("FAIL rd_switch_flags got %b exp 111", {rd_ack, rd_new, rd_valid}); end
    cyc();
    n_checks++; if (rd_new !== 1'b0) begin n_fail++; $display("FAIL rd_new_one_cycle got %b exp 0", rd_new); end
    rd_done = 1'b0;
    cyc();
    n_checks++; if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL rd_ack_drop got %b exp 0", rd_ack); end
  endtask

  task automatic test_overflow_drop();
    apply_reset();
    handshake(1'b1, 1'b0);
    handshake(1'b1, 1'b0);
    n_checks++; if (wr_base !== 32'h0) begin n_fail++; $display("FAIL drop_wr_base got %h exp %h", wr_base, 32'h0); end
    n_checks++; if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL drop_cnt got %0d exp 1", drop_cnt); end
    handshake(1'b0, 1'b1);
    n_checks++; if (rd_base !== 32'h2000) begin n_fail++; $display("FAIL drop_rd_base got %h exp %h", rd_base, 32'h2000); end
  endtask

  task automatic test_underrun_repeat();
    apply_reset();
    rd_done = 1'b1;
    cyc();
    n_checks++; if (rd_base !== 32'h1000) begin n_fail++; $display("FAIL repeat_rd_base got %h exp %h", rd_base, 32'h1000); end
    n_checks++; if (repeat_cnt !== 16'd1) begin n_fail++; $display("FAIL repeat_cnt got %0d exp 1", repeat_cnt); end
    n_checks++; if ({rd_ack, rd_new, rd_valid} !== 3'b100) begin n_fail++; $display("FAIL repeat_flags got %b exp 100", {rd_ack, rd_new, rd_valid}); end
    rd_done = 1'b0;
    cyc();
    n_checks++; if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL repeat_ack_drop got %b exp 0", rd_ack); end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    wr_done = 1'b1; rd_done = 1'b1;
    cyc();
    n_checks++; if (wr_base !== 32'h2000) begin n_fail++; $display("FAIL simul_wr_base got %h exp %h", wr_base, 32'h2000); end
    n_checks++; if (rd_base !== 32'h0) begin n_fail++; $display("FAIL simul_rd_base got %h exp %h", rd_base, 32'h0); end
    n_checks++; if ({wr_ack, rd_ack, rd_new} !== 3'b111) begin n_fail++; $display("FAIL simul_flags got %b exp 111", {wr_ack, rd_ack, rd_new}); end
    wr_done = 1'b0; rd_done = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid_handshake();
    apply_reset();
    wr_done = 1'b1; rd_done = 1'b1;
    cyc();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({wr_ack, rd_ack, rd_valid, rd_new} !== 4'b0) begin n_fail++; $display("FAIL midrst_flags got %b exp 0000", {wr_ack, rd_ack, rd_valid, rd_new}); end
    n_checks++; if (wr_base !== 32'h0 || rd_base !== 32'h1000) begin n_fail++; $display("FAIL midrst_addr got %h %h exp 0 1000", wr_base, rd_base); end
    wr_done = 1'b0; rd_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    cyc();
    n_checks++; if (wr_ack !== 1'b0 || wr_base !== 32'h0) begin n_fail++; $display("FAIL midrst_after got ack %b base %h exp 0 0", wr_ack, wr_base); end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      rd_done4 = 1'b1; cyc();
      rd_done4 = 1'b0; cyc();
    end
    n_checks++; if (repeat_cnt4 !== 2'd3) begin n_fail++; $display("FAIL repeat_saturate got %0d exp 3", repeat_cnt4); end
    wr_done4 = 1'b1; cyc();
    n_checks++; if (wr_base4 !== 32'h2000) begin n_fail++; $display("FAIL n4_wr_base got %h exp %h", wr_base4, 32'h2000); end
    wr_done4 = 1'b0; cyc();
    for (int i = 0; i < 5; i++) begin
      wr_done4 = 1'b1; cyc();
      wr_done4 = 1'b0; cyc();
    end
    n_checks++; if (drop_cnt4 !== 2'd3) begin n_fail++; $display("FAIL drop_saturate got %0d exp 3", drop_cnt4); end
  endtask

  task automatic test_random_stress();
    logic ok3, ok4;
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) wr_done = ~wr_done;
      if ($urandom_range(0, 3) == 0) rd_done = ~rd_done;
      if ($urandom_range(0, 3) == 0) wr_done4 = ~wr_done4;
      if ($urandom_range(0, 3) == 0) rd_done4 = ~rd_done4;
      cyc();
      ok3 = (wr_base != rd_base) && (wr_base[11:0] == 12'h0) && (rd_base[11:0] == 12'h0)
            && (wr_base < 32'h3000) && (rd_base < 32'h3000);
      ok4 = (wr_base4 != rd_base4) && (wr_base4[11:0] == 12'h0) && (rd_base4[11:0] == 12'h0)
            && (wr_base4 < 32'h4000) && (rd_base4 < 32'h4000);
      n_checks++; if (ok3 !== 1'b1) begin n_fail++; $display("FAIL stress_n3 cycle %0d wr %h rd %h", i, wr_base, rd_base); end
      n_checks++; if (ok4 !== 1'b1) begin n_fail++; $display("FAIL stress_n4 cycle %0d wr %h rd %h", i, wr_base4, rd_base4); end
    end
    wr_done = 1'b0; rd_done = 1'b0; wr_done4 = 1'b0; rd_done4 = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_write_then_read();
    test_overflow_drop();
    test_underrun_repeat();
    test_simultaneous();
    test_reset_mid_handshake();
    test_saturate();
    test_random_stress();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
